// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Shared types, lamp encodings and default dwell values for the
//               two-road intersection sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Phase of the intersection sequence. FLASH exists only when the
    // FLASH_MODE_EN build option is enabled, but the encoding is always reserved.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        AR1   = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5,
        AR2   = 3'd6,
        FLASH = 3'd7
    } phase_t;

    // One-hot lamp head encoding {RED, YELLOW, GREEN}
    typedef logic [2:0] light_t;

    localparam light_t LIGHT_RED    = 3'b100;
    localparam light_t LIGHT_YELLOW = 3'b010;
    localparam light_t LIGHT_GREEN  = 3'b001;

    // Default dwell values in clock cycles
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_GREEN_CYC  = 20;
    localparam int DEF_YELLOW_CYC = 4;
    localparam int DEF_ALLRED_CYC = 2;
    localparam int DEF_PED_CYC    = 10;

    // North-south head for a given phase
    function automatic light_t ns_light(input phase_t p);
        case (p)
            NS_G:    return LIGHT_GREEN;
            NS_Y:    return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

    // East-west head for a given phase
    function automatic light_t ew_light(input phase_t p);
        case (p)
            EW_G:    return LIGHT_GREEN;
            EW_Y:    return LIGHT_YELLOW;
            default: return LIGHT_RED;
        endcase
    endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Down-counter for phase dwell. Loads a value, decrements to
//               zero and holds there; done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    // Load has priority; otherwise count down and stick at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Dwell expires on the cycle the count reaches zero
    always_comb begin
        done = (count == '0);
    end

endmodule : dwell_timer
`default_nettype wire

// File: rtl/intersection_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : intersection_phase_ctrl
// Description : Two-road intersection sequencer with all-red clearance and
//               latched pedestrian walk requests. All lamp outputs are
//               registered one cycle behind the phase register.
//               Build option FLASH_MODE_EN adds flash_req and a flashing-
//               yellow FLASH phase entered from IDLE or the end of all-red.
// Revision    : 1.0 - initial release
// ============================================================================
module intersection_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int GREEN_CYC  = DEF_GREEN_CYC,
    parameter int YELLOW_CYC = DEF_YELLOW_CYC,
    parameter int ALLRED_CYC = DEF_ALLRED_CYC,
    parameter int PED_CYC    = DEF_PED_CYC
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic ped_req_ns,
    input  logic ped_req_ew,
`ifdef FLASH_MODE_EN
    input  logic flash_req,
`endif
    output logic ns_red,
    output logic ns_yellow,
    output logic ns_green,
    output logic ew_red,
    output logic ew_yellow,
    output logic ew_green,
    output logic walk_ns,
    output logic walk_ew,
    output logic busy
);

    phase_t             state;
    phase_t             next_state;
    logic               load;
    logic [CNT_W-1:0]   load_val;
    logic [CNT_W-1:0]   count;
    logic               done;
    logic               enter_ns;
    logic               enter_ew;
    logic               pend_ns;
    logic               pend_ew;
    logic               serve_ns;
    logic               serve_ew;
    light_t             ns_head;
    light_t             ew_head;
    logic               walk_ns_d;
    logic               walk_ew_d;
`ifdef FLASH_MODE_EN
    logic               flash_on;
`endif

    // Counter preload for a phase: dwell minus one so the phase lasts DWELL cycles
    function automatic logic [CNT_W-1:0] dwell_of(input phase_t p);
        case (p)
            NS_G, EW_G:  return CNT_W'(GREEN_CYC - 1);
            NS_Y, EW_Y:  return CNT_W'(YELLOW_CYC - 1);
            AR1, AR2:    return CNT_W'(ALLRED_CYC - 1);
            FLASH:       return CNT_W'(YELLOW_CYC - 1);
            default:     return '0;
        endcase
    endfunction

    dwell_timer #(
        .CNT_W (CNT_W)
    ) u_dwell_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .value   (load_val),
        .count   (count),
        .done    (done)
    );

    // Phase register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next phase and timer reload; start is only looked at in IDLE and at the end of all-red
    always_comb begin
        next_state = state;
        load       = 1'b0;
        load_val   = '0;
        case (state)
            IDLE: begin
`ifdef FLASH_MODE_EN
                if (flash_req) next_state = FLASH;
                else
`endif
                if (start)     next_state = NS_G;
            end
            NS_G: if (done) next_state = NS_Y;
            NS_Y: if (done) next_state = AR1;
            AR1: begin
                if (done) begin
`ifdef FLASH_MODE_EN
                    if (flash_req)  next_state = FLASH;
                    else
`endif
                    if (start)      next_state = EW_G;
                    else            next_state = IDLE;
                end
            end
            EW_G: if (done) next_state = EW_Y;
            EW_Y: if (done) next_state = AR2;
            AR2: begin
                if (done) begin
`ifdef FLASH_MODE_EN
                    if (flash_req)  next_state = FLASH;
                    else
`endif
                    if (start)      next_state = NS_G;
                    else            next_state = IDLE;
                end
            end
`ifdef FLASH_MODE_EN
            FLASH: begin
                if (!flash_req) begin
                    next_state = AR2;
                end else if (done) begin
                    // Restart the half-period for the next yellow toggle
                    load     = 1'b1;
                    load_val = dwell_of(FLASH);
                end
            end
`endif
            default: next_state = IDLE;
        endcase
        if (next_state != state) begin
            load     = 1'b1;
            load_val = dwell_of(next_state);
        end
    end

    // Green-entry strobes that decide whether a walk window is granted
    always_comb begin
        enter_ns = (next_state == NS_G) && (state != NS_G);
        enter_ew = (next_state == EW_G) && (state != EW_G);
    end

    // Pedestrian latches: a request on the entry edge is served immediately,
    // one arriving later in the green waits for the next green of that road
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_ns  <= 1'b0;
            pend_ew  <= 1'b0;
            serve_ns <= 1'b0;
            serve_ew <= 1'b0;
        end else begin
            if (enter_ns) begin
                serve_ns <= pend_ns | ped_req_ns;
                pend_ns  <= 1'b0;
            end else begin
                if (ped_req_ns) pend_ns <= 1'b1;
                if (next_state != NS_G) serve_ns <= 1'b0;
            end
            if (enter_ew) begin
                serve_ew <= pend_ew | ped_req_ew;
                pend_ew  <= 1'b0;
            end else begin
                if (ped_req_ew) pend_ew <= 1'b1;
                if (next_state != EW_G) serve_ew <= 1'b0;
            end
        end
    end

`ifdef FLASH_MODE_EN
    // Flashing yellow level: starts lit and toggles each time the half-period expires
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flash_on <= 1'b0;
        end else if (state != FLASH) begin
            flash_on <= 1'b1;
        end else if (done && flash_req) begin
            flash_on <= ~flash_on;
        end
    end
`endif

    // Lamp decode; walk covers the first PED_CYC cycles of a served green
    always_comb begin
        ns_head   = ns_light(state);
        ew_head   = ew_light(state);
        walk_ns_d = (state == NS_G) && serve_ns && (count >= CNT_W'(GREEN_CYC - PED_CYC));
        walk_ew_d = (state == EW_G) && serve_ew && (count >= CNT_W'(GREEN_CYC - PED_CYC));
`ifdef FLASH_MODE_EN
        if (state == FLASH) begin
            ns_head = {1'b0, flash_on, 1'b0};
            ew_head = {1'b0, flash_on, 1'b0};
        end
`endif
    end

    // Registered lamp and status outputs; reset forces both heads red at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {ns_red, ns_yellow, ns_green} <= LIGHT_RED;
            {ew_red, ew_yellow, ew_green} <= LIGHT_RED;
            walk_ns <= 1'b0;
            walk_ew <= 1'b0;
            busy    <= 1'b0;
        end else begin
            {ns_red, ns_yellow, ns_green} <= ns_head;
            {ew_red, ew_yellow, ew_green} <= ew_head;
            walk_ns <= walk_ns_d;
            walk_ew <= walk_ew_d;
            busy    <= (state != IDLE);
        end
    end

endmodule : intersection_phase_ctrl
`default_nettype wire

// File: tb/tb_intersection_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_intersection_phase_ctrl
// Description : Randomized self-checking bench for intersection_phase_ctrl.
//               A phase-table model predicts every lamp each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_intersection_phase_ctrl;

    localparam int GREEN  = 20;
    localparam int YELLOW = 4;
    localparam int ALLRED = 2;
    localparam int PED    = 10;
    localparam logic [8:0] RESET_VEC = 9'b100_100_000;

    logic clk        = 1'b0;
    logic reset_n    = 1'b0;
    logic start      = 1'b0;
    logic ped_req_ns = 1'b0;
    logic ped_req_ew = 1'b0;
`ifdef FLASH_MODE_EN
    logic flash_req  = 1'b0;
`endif
    logic ns_red, ns_yellow, ns_green;
    logic ew_red, ew_yellow, ew_green;
    logic walk_ns, walk_ew, busy;

    int n_cmp = 0;
    int n_bad = 0;

    intersection_phase_ctrl #(
        .CNT_W      (8),
        .GREEN_CYC  (GREEN),
        .YELLOW_CYC (YELLOW),
        .ALLRED_CYC (ALLRED),
        .PED_CYC    (PED)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .ped_req_ns (ped_req_ns),
        .ped_req_ew (ped_req_ew),
`ifdef FLASH_MODE_EN
        .flash_req  (flash_req),
`endif
        .ns_red     (ns_red),
        .ns_yellow  (ns_yellow),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_yellow  (ew_yellow),
        .ew_green   (ew_green),
        .walk_ns    (walk_ns),
        .walk_ew    (walk_ew),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [8:0] got, input logic [8:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Reference model: cyclic phase table (0 NS_G,1 NS_Y,2 AR1,3 EW_G,4 EW_Y,5 AR2), -1 idle,
    // with elapsed cycles counted upward inside the phase.
    int m_ph = -1;
    int m_el = 0;
    int dur [6] = '{GREEN, YELLOW, ALLRED, GREEN, YELLOW, ALLRED};
    bit m_pend_ns = 0, m_pend_ew = 0, m_srv_ns = 0, m_srv_ew = 0;
    logic [8:0] exp_vec = RESET_VEC;

    function automatic logic [8:0] model_lamps();
        logic [2:0] ns, ew;
        logic wn, we, bz;
        ns = (m_ph == 0) ? 3'b001 : (m_ph == 1) ? 3'b010 : 3'b100;
        ew = (m_ph == 3) ? 3'b001 : (m_ph == 4) ? 3'b010 : 3'b100;
        wn = (m_ph == 0) && m_srv_ns && (m_el < PED);
        we = (m_ph == 3) && m_srv_ew && (m_el < PED);
        bz = (m_ph != -1);
        return {ns, ew, wn, we, bz};
    endfunction

    task automatic model_step();
        int  nxt;
        bit  moved;
        if (!reset_n) begin
            m_ph = -1; m_el = 0;
            m_pend_ns = 0; m_pend_ew = 0; m_srv_ns = 0; m_srv_ew = 0;
            exp_vec = RESET_VEC;
            return;
        end
        exp_vec = model_lamps();
        nxt   = m_ph;
        moved = 0;
        if (m_ph < 0) begin
            if (start) begin nxt = 0; moved = 1; end
        end else if (m_el + 1 >= dur[m_ph]) begin
            moved = 1;
            nxt = ((m_ph == 2 || m_ph == 5) && !start) ? -1 : (m_ph + 1) % 6;
        end
        if (moved && nxt == 0) begin
            m_srv_ns  = m_pend_ns | ped_req_ns;
            m_pend_ns = 0;
        end else if (ped_req_ns) m_pend_ns = 1;
        if (moved && nxt == 3) begin
            m_srv_ew  = m_pend_ew | ped_req_ew;
            m_pend_ew = 0;
        end else if (ped_req_ew) m_pend_ew = 1;
        if (moved) begin
            m_ph = nxt;
            m_el = 0;
        end else if (m_ph >= 0) begin
            m_el++;
        end
    endtask

    // Advance the model on every edge and compare the registered lamps just after it
    always @(posedge clk) begin
        model_step();
        #1;
        check_val("lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                            walk_ns, walk_ew, busy}, exp_vec);
        check_val("conflict", {8'd0, (!ns_red && !ew_red)}, 9'd0);
    end

    task automatic rand_peds(input int odds);
        ped_req_ns = ($urandom_range(0, odds - 1) == 0);
        ped_req_ew = ($urandom_range(0, odds - 1) == 0);
    endtask

    initial begin
        int w;
        // Reset for two cycles, then idle with start low
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Continuous running with sparse pedestrian pulses
        start = 1'b1;
        repeat (600) begin
            @(negedge clk);
            rand_peds(25);
        end

        // Start toggling occasionally, denser requests to hit entry-edge cases
        repeat (2000) begin
            @(negedge clk);
            if ($urandom_range(0, 119) == 0) start = ~start;
            rand_peds(6);
        end

        // Asynchronous reset in the middle of NS yellow
        ped_req_ns = 1'b0;
        ped_req_ew = 1'b0;
        start      = 1'b1;
        w = 0;
        while (m_ph != 1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #3;
        check_val("pre_reset_yellow", {8'd0, ns_yellow}, 9'd1);
        reset_n = 1'b0;
        #1;
        check_val("async_reset", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
                                  walk_ns, walk_ew, busy}, RESET_VEC);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Resume after reset
        repeat (300) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) start = ~start;
            rand_peds(8);
        end

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_intersection_phase_ctrl
`default_nettype wire
